// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Owns the single write port of an NREG x DW register file. Two writeback
// sources compete for that port, and a round-robin pointer decides between
// them when both are valid in the same cycle. A clear sequencer can take the
// port over and write zero to every register, one address per cycle.
//
// Every output that faces the register file comes from a flop, so a write
// accepted at one rising edge is presented to the file during the cycle that
// follows that edge.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   req0_valid   ALU writeback request           (in)
//   req0_adr     ALU writeback address           (in,  AW)
//   req0_data    ALU writeback data              (in,  DW)
//   req0_ready   ALU write accepted this cycle   (out, combinational)
//   req1_valid   load writeback request          (in)
//   req1_adr     load writeback address          (in,  AW)
//   req1_data    load writeback data             (in,  DW)
//   req1_ready   load write accepted this cycle  (out, combinational)
//   clr_start    start a full register-file clear (in)
//   clr_busy     clear sequence in progress      (out)
//   clr_done     one-cycle pulse at clear end    (out)
//   rf_W_Adr     register file write address     (out, AW)
//   rf_we        register file write enable      (out)
//   rf_W         register file write data        (out, DW)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_adr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_adr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] rf_W_Adr,
  output logic          rf_we,
  output logic [DW-1:0] rf_W
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_ADR = AW'(NREG - 1);

  state_e        state_q;
  logic          prio_q;     // 0: req0 favoured, 1: req1 favoured
  logic [AW-1:0] cnt_q;      // address issued in the current clear cycle
  logic          rf_we_q;
  logic [AW-1:0] rf_adr_q;
  logic [DW-1:0] rf_w_q;
  logic          clr_busy_q;
  logic          clr_done_q;

  logic accept_ok;
  logic grant0;
  logic grant1;

  // A clear request in IDLE wins over both requesters for that cycle.
  assign accept_ok = (state_q == IDLE) && !clr_start;

  // The priority pointer only matters under contention; a lone requester is
  // always granted.
  assign grant0 = accept_ok && req0_valid && (!req1_valid || !prio_q);
  assign grant1 = accept_ok && req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rf_we    = rf_we_q;
  assign rf_W_Adr = rf_adr_q;
  assign rf_W     = rf_w_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_adr_q   <= '0;
      rf_w_q     <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      // NOTE: defaults at the top make clr_done a single-cycle pulse and keep
      // every branch below from having to repeat it.
      clr_done_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rf_we_q    <= 1'b1;
            rf_adr_q   <= '0;
            rf_w_q     <= '0;
            clr_busy_q <= 1'b1;
          end else if (grant0) begin
            rf_we_q  <= 1'b1;
            rf_adr_q <= req0_adr;
            rf_w_q   <= req0_data;
            prio_q   <= 1'b1;
          end else if (grant1) begin
            rf_we_q  <= 1'b1;
            rf_adr_q <= req1_adr;
            rf_w_q   <= req1_data;
            prio_q   <= 1'b0;
          end else begin
            // Address and data hold their last value while idle.
            rf_we_q <= 1'b0;
          end
        end

        CLEAR: begin
          // clr_start is not looked at here, so a repeat request mid-clear
          // is dropped rather than queued.
          if (cnt_q == LAST_ADR) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q + AW'(1);
            rf_we_q  <= 1'b1;
            rf_adr_q <= cnt_q + AW'(1);
            rf_w_q   <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [AW-1:0] req0_adr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_adr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] rf_W_Adr;
  logic          rf_we;
  logic [DW-1:0] rf_W;

  regfile_write_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_adr   (req0_adr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_adr   (req1_adr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .rf_W_Adr   (rf_W_Adr),
    .rf_we      (rf_we),
    .rf_W       (rf_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: cycle-level view of the port owner. A clear is tracked
  // as "next address to issue" (-1 when not clearing, NREG when the done
  // pulse is due); arbitration is a favoured-requester index.
  // ---------------------------------------------------------------------------
  bit            m_known = 0;
  int            m_next  = -1;
  int            m_fav   = 0;
  logic          m_we, m_busy, m_done;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_w;

  function automatic logic model_grant(input int who);
    bit idle = (m_next < 0);
    if (who == 0) return idle && !clr_start && req0_valid && (!req1_valid || m_fav == 0);
    else          return idle && !clr_start && req1_valid && (!req0_valid || m_fav == 1);
  endfunction

  task automatic model_edge();
    logic g0, g1;
    g0 = model_grant(0);
    g1 = model_grant(1);
    if (!rst) begin
      m_known = 1; m_next = -1; m_fav = 0;
      m_we = 0; m_adr = '0; m_w = '0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_next < 0) begin
        if (clr_start) begin
          m_we = 1; m_adr = '0; m_w = '0; m_busy = 1; m_next = 1;
        end else if (g0) begin
          m_we = 1; m_adr = req0_adr; m_w = req0_data; m_fav = 1;
        end else if (g1) begin
          m_we = 1; m_adr = req1_adr; m_w = req1_data; m_fav = 0;
        end else begin
          m_we = 0;
        end
      end else if (m_next == NREG) begin
        m_we = 0; m_busy = 0; m_done = 1; m_next = -1;
      end else begin
        m_we = 1; m_adr = AW'(m_next); m_w = '0; m_next++;
      end
    end
  endtask

  logic s_rdy0, s_rdy1;

  // Drives one cycle of inputs, checks readies before the edge and outputs
  // one time unit after it, both against the model.
  task automatic step(input logic r, input logic v0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic v1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic cs);
    rst = r; req0_valid = v0; req0_adr = a0; req0_data = d0;
    req1_valid = v1; req1_adr = a1; req1_data = d1; clr_start = cs;
    #1;
    s_rdy0 = req0_ready;
    s_rdy1 = req1_ready;
    if (m_known)
      check("model_rdy", {62'd0, s_rdy0, s_rdy1}, {62'd0, model_grant(0), model_grant(1)});
    @(posedge clk);
    model_edge();
    #1;
    if (m_known)
      check("model_out", {42'd0, rf_we, rf_W_Adr, rf_W, clr_busy, clr_done},
                         {42'd0, m_we, m_adr, m_w, m_busy, m_done});
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle, readies expected before the edge,
  // outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          rst;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          cs;
    logic          chk_rdy;
    logic          r0;
    logic          r1;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] w;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, stray;

    //             rst v0 a0 d0        v1 a1 d1        cs ck r0 r1 we adr w        bz dn
    vecs[0]  = '{1'b0,1'b1,3'd7,16'hFFFF,1'b1,3'd6,16'hAAAA,1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,3'd7,16'hFFFF,1'b1,3'd6,16'hAAAA,1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,3'd5,16'hBEEF,1'b0,3'd0,16'h0000,1'b0,1'b1,1'b1,1'b0,1'b1,3'd5,16'hBEEF,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,3'd5,16'hBEEF,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,16'h0000,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,3'd1,16'h1111,1'b1,3'd2,16'h2222,1'b0,1'b1,1'b1,1'b0,1'b1,3'd1,16'h1111,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b1,3'd1,16'h1111,1'b1,3'd2,16'h2222,1'b0,1'b1,1'b0,1'b1,1'b1,3'd2,16'h2222,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b1,3'd1,16'h1111,1'b1,3'd2,16'h2222,1'b0,1'b1,1'b1,1'b0,1'b1,3'd1,16'h1111,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b1,3'd1,16'h1111,1'b1,3'd2,16'h2222,1'b0,1'b1,1'b0,1'b1,1'b1,3'd2,16'h2222,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,16'h2222,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,3'd3,16'h3333,1'b0,1'b1,1'b0,1'b1,1'b1,3'd3,16'h3333,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,3'd4,16'h4444,1'b0,1'b1,1'b0,1'b1,1'b1,3'd4,16'h4444,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,3'd4,16'h4444,1'b0,1'b0};

    rst = 1'b0; req0_valid = 1'b0; req0_adr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_adr = '0; req1_data = '0; clr_start = 1'b0;
    #1;

    // Reset, single requester, contention and lone-requester vectors.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0,
           vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].cs);
      if (vecs[i].chk_rdy)
        check($sformatf("vec%0d_rdy", i), {62'd0, s_rdy0, s_rdy1},
              {62'd0, vecs[i].r0, vecs[i].r1});
      check($sformatf("vec%0d_out", i), {42'd0, rf_we, rf_W_Adr, rf_W, clr_busy, clr_done},
            {42'd0, vecs[i].we, vecs[i].adr, vecs[i].w, vecs[i].busy, vecs[i].done});
    end

    // Clear with a pending req1: blocked for the whole clear, granted in the
    // clr_done cycle, written the cycle after.
    for (int k = 0; k < NREG; k++) begin
      step(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 16'h4C4C, (k == 0));
      check($sformatf("clr_rdy1_%0d", k), {63'd0, s_rdy1}, 64'd0);
      check($sformatf("clr_wr_%0d", k), {44'd0, rf_we, clr_busy, rf_W_Adr, rf_W},
            {44'd0, 1'b1, 1'b1, AW'(k), 16'h0000});
    end
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 16'h4C4C, 1'b0);
    check("clr_last_rdy1", {63'd0, s_rdy1}, 64'd0);
    check("clr_done_pulse", {61'd0, rf_we, clr_busy, clr_done}, {61'd0, 3'b001});
    step(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 16'h4C4C, 1'b0);
    check("clr_done_grant", {63'd0, s_rdy1}, 64'd1);
    check("clr_after_write", {41'd0, rf_we, rf_W_Adr, rf_W, clr_done},
          {41'd0, 1'b1, 3'd4, 16'h4C4C, 1'b0});
    idle_step();

    // Clear aborted by reset while address 3 is being written.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, (k == 0));
    check("abort_at3", {62'd0, rf_W_Adr == 3'd3, clr_busy}, {62'd0, 2'b11});
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    check("abort_out", {62'd0, rf_we, clr_busy}, 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      idle_step();
      if (clr_done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    step(1'b1, 1'b1, 3'd6, 16'h0A0A, 1'b1, 3'd6, 16'h0B0B, 1'b0);
    check("abort_prio0", {62'd0, s_rdy0, s_rdy1}, {62'd0, 2'b10});
    idle_step();

    // Restart mid-clear is ignored; a req0 raised and dropped during the
    // clear never writes.
    busy_cnt = 0; done_cnt = 0; stray = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k == 3), 3'd6, 16'h6666, 1'b0, '0, '0, (k == 0 || k == 2));
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (rf_we && rf_W == 16'h6666) stray++;
    end
    check("restart_busy", 64'(busy_cnt), 64'(NREG));
    check("restart_done", 64'(done_cnt), 64'd1);
    check("dropped_req0", 64'(stray), 64'd0);

    // Randomized traffic against the model, including stretches of held
    // clr_start and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom),
           ($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom),
           ((i % 150) < 25) || ($urandom_range(0, 19) == 0));
      check("one_ready", {63'd0, s_rdy0 && s_rdy1}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (W_Adr / we / W) of the 8 x 16 register file.
- Arbitrates round-robin between two write requesters: req0 (ALU writeback) and req1 (memory load writeback).
- Provides a clear sequencer that zeroes all registers, one register per cycle, on command.
- All register-file-facing outputs are registered, so each granted write reaches the file exactly one cycle after acceptance.

Parameters:
- DW, 16, data width of write data.
- AW, 3, register address width.
- NREG, 8, number of registers; must equal 2**AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 sampled at a rising edge resets the block.
- req0_valid  input  1  requester 0 has a write pending.
- req0_adr  input  AW  requester 0 target register.
- req0_data  input  DW  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_adr  input  AW  requester 1 target register.
- req1_data  input  DW  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle (combinational).
- clr_start  input  1  request a full register-file clear.
- clr_busy  output  1  clear sequence in progress.
- clr_done  output  1  one-cycle pulse when the clear completes.
- rf_W_Adr  output  AW  to register file W_Adr.
- rf_we  output  1  to register file we.
- rf_W  output  DW  to register file W.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, prio=0 (req0 favoured), clear counter=0.
  - rf_we=0, rf_W_Adr=0, rf_W=0, clr_busy=0, clr_done=0.
  - Reset mid-clear aborts the clear immediately; there is no clr_done for the aborted sequence.
- States:
  - IDLE → CLEAR when clr_start=1.
  - CLEAR → IDLE after the write to address NREG-1 has been issued.
- Handshake:
  - A transfer occurs when valid & ready at a rising edge.
  - A requester holds valid, adr and data stable until it sees ready.
  - Deasserting valid before ready is permitted; the request is simply dropped.
- Ready (combinational):
  - req0_ready = IDLE & !clr_start & req0_valid & (!req1_valid | prio==0).
  - req1_ready = IDLE & !clr_start & req1_valid & (!req0_valid | prio==1).
  - At most one ready is high in any cycle.
- Round-robin:
  - After a grant to reqN, prio points to the other requester.
  - When there is no grant, prio holds.
  - A lone requester is granted every cycle regardless of prio.
- Write issue:
  - On an accepted transfer at edge N, rf_we=1 with rf_W_Adr and rf_W taken from the granted requester during the cycle after edge N.
  - With no transfer, rf_we=0.
  - rf_W_Adr and rf_W hold their last value when rf_we=0.
- Clear sequence:
  - clr_start sampled in IDLE at edge N: no request is accepted that cycle (clear wins).
  - From edge N, rf_we=1, rf_W=0, clr_busy=1, with rf_W_Adr = 0, 1, ..., NREG-1 on consecutive cycles. That is exactly NREG cycles of rf_we=1 and clr_busy=1.
  - At the edge after address NREG-1: rf_we=0, clr_busy=0, clr_done=1 for one cycle, state=IDLE.
  - Requests are accepted again in the clr_done cycle.
  - clr_start while in CLEAR is ignored; it is not queued.
  - clr_start held high continuously restarts a clear in the cycle after clr_done.
- Same-address simultaneous requests: only the granted one writes; the other stays pending and writes on a later cycle (last writer wins).
- The block never issues two writes in one cycle. Maximum throughput is one write per cycle.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with all inputs active → rf_we=0, rf_W_Adr=0, rf_W=0, clr_busy=0, clr_done=0, both readies 0 during reset.
2. Single requester:
   - Stimulus: req0_valid=1, adr=5, data=16'hBEEF for one cycle.
   - Expected: req0_ready=1 that cycle; the next cycle rf_we=1, rf_W_Adr=5, rf_W=16'hBEEF; the cycle after, rf_we=0.
3. Contention:
   - Stimulus: both valid continuously; req0 (adr=1, data=16'h1111) and req1 (adr=2, data=16'h2222).
   - Expected: grants alternate req0, req1, req0, req1 starting with req0 after reset; rf writes alternate addresses 1, 2, 1, 2 with matching data, one per cycle.
4. Clear:
   - Stimulus: pulse clr_start with req1_valid=1.
   - Expected: req1_ready=0 throughout; clr_busy=1 for 8 cycles while rf_W_Adr steps 0..7 with rf_W=0 and rf_we=1; clr_done=1 for exactly 1 cycle; req1 granted in that cycle; its write appears the following cycle.
5. Clear abort: assert rst=0 at the 4th cycle of a clear (rf_W_Adr=3) → the next cycle has rf_we=0 and clr_busy=0, no clr_done follows, and the state is IDLE with prio=0.
6. Ignored restart and dropped request:
   - Stimulus: assert clr_start again mid-clear; separately raise req0_valid for one cycle during CLEAR, then drop it.
   - Expected: a single 8-cycle sequence and one clr_done; no rf write for req0 afterwards.
